// File: rtl/serial_add_seq.sv
// Bit-serial adder sequencer: streams two WIDTH-bit operands LSB-first through
// one full-adder cell with a registered carry, then presents {cout, sum}.
module serial_add_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] s_sr_q, s_sr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             bit_s, carry_nxt;

  always_comb begin
    state_d   = state_q;
    a_sr_d    = a_sr_q;
    b_sr_d    = b_sr_q;
    s_sr_d    = s_sr_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    busy_d    = busy_q;
    done_d    = done_q;
    bit_s     = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    carry_nxt = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));

    // With ena low every register keeps its value, which also stretches done.
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr_d  = a;
            b_sr_d  = b;
            carry_d = cin;
            cnt_d   = '0;
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end
        SHIFT: begin
          a_sr_d  = a_sr_q >> 1;
          b_sr_d  = b_sr_q >> 1;
          s_sr_d  = {bit_s, s_sr_q[WIDTH-1:1]};
          carry_d = carry_nxt;
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            // Final bit goes straight to the outputs, bypassing s_sr.
            sum_d   = {bit_s, s_sr_q[WIDTH-1:1]};
            cout_d  = carry_nxt;
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        DONE: begin
          state_d = IDLE;
          done_d  = 1'b0;
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sr_q  <= '0;
      b_sr_q  <= '0;
      s_sr_q  <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sr_q  <= a_sr_d;
      b_sr_q  <= b_sr_d;
      s_sr_q  <= s_sr_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq (WIDTH=8): hand-computed sums, latency,
// start-while-busy, ena freeze and asynchronous reset.
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic [7:0] a, b;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] sum;

  int checks = 0;
  int errors = 0;

  serial_add_seq #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start),
    .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Start at E0, then check busy through E1..E7, result after E8, done low after E9.
  task automatic do_add(input string tag, input logic [7:0] ai, input logic [7:0] bi,
                        input logic ci, input logic [7:0] es, input logic ec);
    a = ai; b = bi; cin = ci; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    for (int i = 1; i < 8; i++) tick();
    chk({tag, "_busy_e7"}, {31'd0, busy}, 32'd1);
    chk({tag, "_done_e7"}, {31'd0, done}, 32'd0);
    tick();
    chk({tag, "_done_e8"}, {31'd0, done}, 32'd1);
    chk({tag, "_busy_e8"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sum"},     {24'd0, sum},  {24'd0, es});
    chk({tag, "_cout"},    {31'd0, cout}, {31'd0, ec});
    tick();
    chk({tag, "_done_e9"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // 1: reset, then idle with start low
    tick(); tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_sum",  {24'd0, sum},  32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_state", {29'd0, busy, done, cout}, 32'd0);
      chk("idle_sum", {24'd0, sum}, 32'd0);
    end

    // 2, 3: basic add and full carry ripple
    do_add("add35_4a", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    do_add("addff_00", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
    do_add("addff_ff", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);

    // 4: start while busy ignored; start in DONE ignored; re-accept at E10
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick(); tick();                           // E1, E2
    a = 8'h80; b = 8'h80; start = 1'b1;
    tick();                                   // E3
    start = 1'b0;
    chk("ign_busy_e3", {31'd0, busy}, 32'd1);
    for (int i = 4; i < 8; i++) begin
      tick();
      chk("ign_nodone", {31'd0, done}, 32'd0);
    end
    tick();                                   // E8
    chk("ign_done_e8", {31'd0, done}, 32'd1);
    chk("ign_sum",  {24'd0, sum},  32'h02);
    chk("ign_cout", {31'd0, cout}, 32'd0);
    a = 8'h03; b = 8'h04; start = 1'b1;
    tick();                                   // E9: start in DONE ignored
    chk("ign_done_e9", {31'd0, done}, 32'd0);
    chk("ign_busy_e9", {31'd0, busy}, 32'd0);
    tick();                                   // E10: accepted
    start = 1'b0;
    chk("reacc_busy_e10", {31'd0, busy}, 32'd1);
    for (int i = 1; i < 8; i++) tick();
    chk("reacc_nodone", {31'd0, done}, 32'd0);
    tick();
    chk("reacc_done", {31'd0, done}, 32'd1);
    chk("reacc_sum",  {24'd0, sum},  32'h07);
    tick();
    chk("reacc_done_off", {31'd0, done}, 32'd0);

    // 5: ena gating at cnt=3 delays completion by 5 cycles; done stretches under ena=0
    a = 8'h0F; b = 8'h01; cin = 1'b0; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    tick(); tick(); tick();                   // cnt=3
    ena = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("ena_hold_busy", {31'd0, busy}, 32'd1);
      chk("ena_hold_done", {31'd0, done}, 32'd0);
    end
    ena = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("ena_nodone_early", {31'd0, done}, 32'd0);
    tick();
    chk("ena_done",  {31'd0, done}, 32'd1);
    chk("ena_sum",   {24'd0, sum},  32'h10);
    chk("ena_cout",  {31'd0, cout}, 32'd0);
    ena = 1'b0;
    tick(); tick();
    chk("ena_done_stretch", {31'd0, done}, 32'd1);
    ena = 1'b1;
    tick();
    chk("ena_done_off", {31'd0, done}, 32'd0);

    // 6: async reset between E4 and E5
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    tick();                                   // E0
    start = 1'b0;
    for (int i = 1; i <= 4; i++) tick();      // through E4
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_sum",  {24'd0, sum},  32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("arst_hold_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_nodone", {31'd0, done}, 32'd0);
    end
    do_add("add10_20", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
